// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W    = 4;
  localparam int ADD3_THRESHOLD = 4;

  // True when DIGITS decimal digits can hold every W-bit unsigned value.
  function automatic bit digits_fit(input int unsigned w, input int unsigned d);
    longint unsigned p10;
    longint unsigned maxv;
    p10 = 64'd1;
    for (int unsigned i = 0; i < d; i++) begin
      p10 = p10 * 64'd10;
    end
    maxv = (64'd1 << w) - 64'd1;
    return p10 > maxv;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit above the threshold.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // Pass through small digits, otherwise add 3 (wraps mod 16).
  always_comb begin
    o_digit = i_digit;
    if (i_digit > BCD_DIGIT_W'(ADD3_THRESHOLD)) begin
      o_digit = i_digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to packed BCD converter, one bit per cycle.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  input  logic                  is_signed,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int SW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(W + 1);

  if (W < 4) begin : g_w_err
    $error("bin_to_bcd_seq: W must be at least 4");
  end
  if (!digits_fit(W, DIGITS)) begin : g_digits_err
    $error("bin_to_bcd_seq: DIGITS too small for W-bit input");
  end

  state_t          r_state;
  logic [W-1:0]    r_sr;
  logic [SW-1:0]   r_scratch;
  logic [CW-1:0]   r_cnt;
  logic            r_sign;
  logic            r_busy;
  logic            r_done;
  logic [SW-1:0]   r_bcd;
  logic            r_neg;

  logic [SW-1:0]   w_adj;
  logic [SW-1:0]   w_scratch_nxt;
  logic [W-1:0]    w_sr_nxt;
  logic [W-1:0]    w_mag;
  logic            w_sign;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Next shift step and input magnitude/sign.
  always_comb begin
    w_scratch_nxt = {w_adj[SW-2:0], r_sr[W-1]};
    w_sr_nxt      = {r_sr[W-2:0], 1'b0};
    w_sign        = is_signed & bin[W-1];
    w_mag         = w_sign ? (~bin + {{(W-1){1'b0}}, 1'b1}) : bin;
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sr      <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_sr      <= w_mag;
            r_scratch <= '0;
            r_cnt     <= CW'(W);
            r_sign    <= w_sign;
            r_busy    <= 1'b1;
            r_state   <= CONV;
          end else begin
            r_state <= IDLE;
          end
        end
        CONV: begin
          r_scratch <= w_scratch_nxt;
          r_sr      <= w_sr_nxt;
          r_cnt     <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bcd   <= w_scratch_nxt;
            r_neg   <= r_sign;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign neg  = r_neg;

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning the binary input width in bits (W >= 4).
REQ-002 The block SHALL have parameter DIGITS, default 5, meaning the number of BCD output digits; elaboration SHALL fail if 10^DIGITS <= 2^W - 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a conversion, sampled on the clk edge.
REQ-006 The block SHALL have port bin, input, W bits: the value to convert, sampled with start.
REQ-007 The block SHALL have port is_signed, input, 1 bit: 1 means bin is two's complement, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: a conversion is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port bcd, output, 4*DIGITS bits: the packed BCD result, most significant digit in the top nibble.
REQ-011 The block SHALL have port neg, output, 1 bit: the sign of the result (1 means negative).

Function
REQ-012 The block SHALL implement FSM states IDLE, CONV and DONE.
REQ-013 In IDLE or DONE with start=1, the block SHALL: latch the magnitude of bin into shift register sr (W bits); clear scratch digits; set cnt=W; latch sign_q; go to CONV.
REQ-014 Magnitude: if is_signed=1 and bin[W-1]=1, the block SHALL use the W-bit unsigned value (~bin+1), so -2^(W-1) gives 2^(W-1); otherwise it SHALL use bin unchanged.
REQ-015 sign_q SHALL equal is_signed & bin[W-1].
REQ-016 Each CONV cycle, the block SHALL first add 3 (mod 16) to every scratch digit > 4, then shift {scratch, sr} left by 1, then decrement cnt.
REQ-017 When cnt=1 in CONV, the block SHALL perform the final step and go to DONE.
REQ-018 On entering DONE, the block SHALL load bcd from scratch, set neg from sign_q and assert done.
REQ-019 DONE SHALL last exactly one cycle; the next state SHALL be IDLE, or CONV if start=1.
REQ-020 Latency: if start is sampled at edge k, done SHALL be high between edges k+W and k+W+1.
REQ-021 busy SHALL be 1 exactly while the state is CONV.
REQ-022 start SHALL be ignored while busy=1; bin and is_signed SHALL NOT affect a conversion in flight.
REQ-023 bcd and neg SHALL hold their last values until the next DONE.
REQ-024 Every bcd digit SHALL be in the range 0..9.
REQ-025 With DIGITS sufficient per REQ-002, no overflow SHALL occur.

Reset
REQ-026 When rst=1 at a clk edge, the block SHALL set the state to IDLE, busy=0, done=0, bcd=0, neg=0, and cnt, sr, scratch and sign_q to 0.
REQ-027 rst SHALL take priority over start.
REQ-028 rst during CONV SHALL abort the conversion with no done pulse.
REQ-029 The first start after reset is released SHALL be accepted normally.

Structure
REQ-030 Shared package bcd_pkg SHALL hold: the FSM state encoding (IDLE, CONV, DONE); the constant BCD_DIGIT_W=4; the constant ADD3_THRESHOLD=4.
REQ-031 Sub-module bcd_digit_adj SHALL be a combinational block: 4-bit in, 4-bit out, add 3 if input > 4, otherwise pass through.
REQ-032 bcd_digit_adj SHALL be instantiated DIGITS times inside bin_to_bcd_seq.
REQ-033 All state SHALL be in a single clk domain; there SHALL be no latches and no combinational path from bin to bcd.

Verification
REQ-034 W=16, DIGITS=5, bin=16'hFFFF, is_signed=0, start pulse -> done exactly 16 cycles later, bcd=20'h65535, neg=0, busy high for those 16 cycles.
REQ-035 bin=16'h0000 -> bcd=20'h00000, neg=0; bin=16'd9999 -> bcd=20'h09999.
REQ-036 is_signed=1: bin=16'h8000 -> bcd=20'h32768, neg=1; bin=16'hFFFF -> bcd=20'h00001, neg=1; bin=16'h7FFF -> bcd=20'h32767, neg=0.
REQ-037 Start bin=16'd1234; at cycle 5 pulse start with bin=16'd9999 -> a single done with bcd=20'h01234; the second start is dropped.
REQ-038 rst=1 at cycle 8 of a conversion -> no done, all outputs 0; a following start with bin=16'd42 -> bcd=20'h00042.
REQ-039 start held high continuously with bin=16'd500 -> a done pulse every 17 cycles (start taken in DONE), each with bcd=20'h00500.
